// File: rtl/corr_pkg.sv
// Shared definitions for the correlator MAC bank and its readout path.
package corr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    CAPTURE,
    DRAIN
  } rd_state_e;

  localparam int DEF_N_LAG    = 8;
  localparam int DEF_DIM_ADD  = 64;
  localparam int DEF_PIPE_LAT = 3;

endpackage

// File: rtl/readout_shadow.sv
// Shadow bank holding one snapshot of every MAC accumulator,
// read back one lag at a time.
module readout_shadow #(
  parameter int N_LAG   = 8,
  parameter int DIM_ADD = 64,
  parameter int LAG_W   = $clog2(N_LAG)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic [N_LAG*DIM_ADD-1:0] acc_i,
  input  logic [LAG_W-1:0]         rd_lag_i,
  output logic [DIM_ADD-1:0]       rd_data_o
);

  logic [DIM_ADD-1:0] bank_q [N_LAG];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < N_LAG; k++) begin
        bank_q[k] <= '0;
      end
    end else if (load_i) begin
      for (int k = 0; k < N_LAG; k++) begin
        bank_q[k] <= acc_i[k*DIM_ADD +: DIM_ADD];
      end
    end
  end

  assign rd_data_o = bank_q[rd_lag_i];

endmodule

// File: rtl/mac_readout.sv
// MAC bank readout: drain the MAC pipeline, snapshot and clear the
// accumulators, then stream the snapshot out over valid/ready.
module mac_readout
  import corr_pkg::*;
#(
  parameter int N_LAG    = DEF_N_LAG,
  parameter int DIM_ADD  = DEF_DIM_ADD,
  parameter int LAG_W    = $clog2(N_LAG),
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     dump,
  input  logic [N_LAG*DIM_ADD-1:0] acc_in,
  output logic                     mac_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM_ADD-1:0]       out_data,
  output logic [LAG_W-1:0]         out_lag,
  output logic                     out_last,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     ovr_clr,
  output logic [15:0]              frame_cnt
);

  localparam int CNT_W = (PIPE_LAT > 2) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(PIPE_LAT - 1);
  localparam logic [LAG_W-1:0] LAG_LAST   = LAG_W'(N_LAG - 1);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [LAG_W-1:0] lag_q, lag_d;
  logic             ovr_q, ovr_d;
  logic [15:0]      frame_q, frame_d;
  logic             last;

  assign last = (lag_q == LAG_LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      flush_q <= '0;
      lag_q   <= '0;
      ovr_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      lag_q   <= lag_d;
      ovr_q   <= ovr_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    lag_d   = lag_q;
    ovr_d   = ovr_q;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        if (dump) begin
          state_d = FLUSH;
          flush_d = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (flush_q == '0) begin
          state_d = CAPTURE;
        end else begin
          flush_d = flush_q - 1'b1;
        end
      end
      CAPTURE: begin
        state_d = DRAIN;
        lag_d   = '0;
      end
      DRAIN: begin
        if (out_ready) begin
          if (last) begin
            state_d = IDLE;
            frame_d = frame_q + 16'd1;
          end else begin
            lag_d = lag_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (ovr_clr) begin
      ovr_d = 1'b0;
    end
    // a dump while draining is dropped; it wins over a same-cycle clear
    if (dump && state_q == DRAIN) begin
      ovr_d = 1'b1;
    end
  end

  readout_shadow #(
    .N_LAG   (N_LAG),
    .DIM_ADD (DIM_ADD),
    .LAG_W   (LAG_W)
  ) u_shadow (
    .clk_i     (clk),
    .rst_ni    (clr_n),
    .load_i    (state_q == CAPTURE),
    .acc_i     (acc_in),
    .rd_lag_i  (lag_q),
    .rd_data_o (out_data)
  );

  assign mac_clr   = (state_q == CAPTURE);
  assign out_valid = (state_q == DRAIN);
  assign out_lag   = lag_q;
  assign out_last  = out_valid && last;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;
  assign frame_cnt = frame_q;

endmodule

// File: doc/mac_readout.md
# mac_readout

Result reader for the correlator MAC bank: on an end-of-integration `dump` pulse it waits for the MAC pipeline to drain and snapshots all N_LAG accumulators into a shadow bank. It clears the MACs with a one-cycle `mac_clr` pulse, then streams the snapshot out one lag per handshake over a valid/ready interface. It sits between the MAC array and the host/DMA path, so the next integration runs while the previous frame is being read.

## Interface
- N_LAG, 8: number of MAC channels (lags); power of two, ≥2
- DIM_ADD, 64: accumulator width per MAC
- LAG_W, $clog2(N_LAG): lag index width
- PIPE_LAT, 3: MAC pipeline depth from `en`-qualified input to accumulator (a_r → mout_r_pipe → mout_r → aout_r)
- clk  in  1  clock
- clr_n  in  1  reset, asynchronous, active-low
- dump  in  1  end-of-integration strobe, sampled on `clk`
- acc_in  in  N_LAG*DIM_ADD  MAC accumulators, lag k at bits [k*DIM_ADD +: DIM_ADD], signed
- mac_clr  out  1  synchronous clear to all MACs, one-cycle pulse
- out_valid  out  1  out_data/out_lag/out_last valid
- out_ready  in  1  downstream accepts the current word
- out_data  out  DIM_ADD  snapshotted accumulator, signed, passed through unchanged
- out_lag  out  LAG_W  lag index of out_data
- out_last  out  1  high with lag N_LAG-1
- busy  out  1  state ≠ IDLE
- overrun  out  1  sticky: a dump was dropped
- ovr_clr  in  1  clears overrun
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0

## Operation
- States: IDLE, FLUSH, CAPTURE, DRAIN.
- IDLE: `dump`=1 → FLUSH, flush counter loaded with PIPE_LAT-1.
- FLUSH: counter decrements each cycle. At 0 → CAPTURE. The MACs keep running, so in-flight products reach aout_r.
- CAPTURE: exactly one cycle. Shadow bank loads acc_in at the end of the cycle. `mac_clr`=1 during this cycle only. Lag index resets to 0. Next state is DRAIN.
- DRAIN: out_valid=1, out_data=shadow[lag], out_lag=lag, out_last=(lag==N_LAG-1).
  - On valid&ready with !out_last: lag increments.
  - On valid&ready with out_last: → IDLE and frame_cnt increments.
- Samples entering the MACs during FLUSH/CAPTURE are lost to the clear. This dead time is PIPE_LAT+1 cycles per frame and is required behaviour.
- `dump` in FLUSH or CAPTURE: ignored, no overrun.
- `dump` in DRAIN, including the final-handshake cycle: dropped and overrun←1. MACs are not cleared, so that integration extends into the next frame.
- overrun: set has priority over ovr_clr when both occur in the same cycle.
- No arithmetic on data. Sign and width are preserved bit-exact.

## Timing
- Reset: state IDLE. mac_clr, out_valid, out_last, busy and overrun are 0. out_data, out_lag, frame_cnt and the shadow bank are 0.
- `dump` sampled high at edge t: FLUSH occupies cycles t+1…t+PIPE_LAT; CAPTURE at t+PIPE_LAT+1 (mac_clr high); first out_valid at t+PIPE_LAT+2.
- With out_ready held high, one word per cycle: the frame ends N_LAG cycles after the first valid, and IDLE is re-entered on the next cycle.
- AXI-style handshake:
  - out_valid never drops without a handshake.
  - While out_valid && !out_ready, out_data, out_lag and out_last are stable.
  - out_valid does not depend combinationally on out_ready.
- All outputs are registered or decoded from registered state only.
- Asynchronous reset mid-frame aborts immediately. mac_clr is forced 0 and the frame is not counted.

## Structure
- The shared package `corr_pkg` holds the state enum (IDLE/FLUSH/CAPTURE/DRAIN) and the default constants PIPE_LAT=3 and DIM_ADD=64, shared with the MAC array top.
- Sub-module `readout_shadow`: N_LAG×DIM_ADD register bank with load enable and a lag-indexed read mux.
- The FSM, counters and flags stay in mac_readout.

## Test plan
- Reset, then N_LAG=8 with acc_in lag k = k+1, pulse dump, out_ready=1 → mac_clr high exactly at t+4; words 1…8 with lags 0…7 on consecutive cycles; out_last on lag 7; frame_cnt=1.
- Backpressure: out_ready toggles 1,0,0,1,… → each word held stable while stalled; no skipped or duplicated lags; 8 handshakes total.
- Signed extremes: lag 0=0x8000_0000_0000_0000, lag 1=0x7FFF_FFFF_FFFF_FFFF, lag 2=-1 → output bit-exact.
- Dump during DRAIN, and dump on the final-handshake cycle → overrun=1, no extra mac_clr. ovr_clr together with a new dump in DRAIN → overrun stays 1. ovr_clr alone → 0.
- Dump during FLUSH → ignored: single mac_clr, overrun=0.
- clr_n asserted mid-DRAIN → all outputs reset asynchronously; next dump produces a full correct frame; frame_cnt counts only completed frames.
